// File: rtl/uart_32_bit_tx.sv
// uart_32_bit_tx: 32-bit UART transmitter.
// Frame format: 1 start bit, 32 data bits sent LSB-first, 1 stop bit, no parity.
// Bit timing comes from baud_tick; one bit lasts TICKS_PER_BIT ticks.
// Optional build macro UART_32_BIT_TX_BUFFER_EN adds a one-entry holding
// register, so a queued word can follow the current frame with no idle gap.
module uart_32_bit_tx #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_tick,
  input  logic        tx_start,
  input  logic [31:0] tx_data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        tx_ready
);

  localparam int TW = $clog2(TICKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   shift_reg;
  logic          tx_q, busy_q, done_q;
  logic          tx_d, busy_d, done_d;
  logic          boundary;
  logic          accept;
  logic          shift_en;
`ifdef UART_32_BIT_TX_BUFFER_EN
  logic [31:0]   buf_data;
  logic          buf_valid;
  logic          load_buf;
  logic          buf_wr;
`endif

  // The last tick of a bit closes that bit.
  assign boundary = baud_tick && (tick_cnt == TW'(TICKS_PER_BIT - 1));

  // Next-state logic and next-value logic for the registered outputs.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
`ifdef UART_32_BIT_TX_BUFFER_EN
    load_buf = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (boundary) begin
          state_d = DATA;
          tx_d    = shift_reg[0];
        end
      end
      DATA: begin
        if (boundary) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd31) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // This is the bit that becomes shift_reg[0] after the shift.
            tx_d = shift_reg[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (boundary) begin
          done_d  = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef UART_32_BIT_TX_BUFFER_EN
          // Chain straight into the next frame when a word is waiting.
          if (buf_valid) begin
            load_buf = 1'b1;
            state_d  = START;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
          end else if (tx_start) begin
            accept  = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, the registered line outputs, and the datapath counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept) begin
        shift_reg <= tx_data;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
`ifdef UART_32_BIT_TX_BUFFER_EN
      end else if (load_buf) begin
        shift_reg <= buf_data;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
`endif
      end else if (state_q != IDLE && baud_tick) begin
        tick_cnt <= boundary ? '0 : tick_cnt + TW'(1);
        if (shift_en) begin
          shift_reg <= {1'b0, shift_reg[31:1]};
          bit_cnt   <= bit_cnt + 5'd1;
        end
      end
    end
  end

`ifdef UART_32_BIT_TX_BUFFER_EN
  // A request that arrives mid-frame is parked here, unless it is taken
  // directly at a STOP boundary.
  assign buf_wr = tx_start && busy_q && !buf_valid && !accept;

  // Holding register: written while busy, drained at the STOP boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (load_buf) begin
      buf_valid <= 1'b0;
    end else if (buf_wr) begin
      buf_valid <= 1'b1;
      buf_data  <= tx_data;
    end
  end

  assign tx_ready = ~buf_valid;
`else
  assign tx_ready = ~busy_q;
`endif

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_32_bit_tx.sv
// tb_uart_32_bit_tx: directed, table-driven bench for uart_32_bit_tx.
// baud_tick pulses once every 4 clk. The serial line is sampled just before
// each tick edge and rebuilt into a 34-bit frame {stop, data, start}. That
// frame is then compared against a hand-computed constant.
module tb_uart_32_bit_tx;

`ifdef UART_32_BIT_TX_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int TPB   = 16;
  localparam int NTICK = 34 * TPB;

  logic        clk = 1'b0;
  logic        rst, baud_tick, tx_start;
  logic [31:0] tx_data;
  logic        tx, busy, done, tx_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  uart_32_bit_tx #(.TICKS_PER_BIT(TPB)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(tx_start),
    .tx_data(tx_data), .tx(tx), .busy(busy), .done(done), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Count done pulses independently of the directed checks.
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [31:0] data;
    int          stall_at;
    int          extra_at;
    logic [31:0] extra;
    logic [33:0] exp_frame;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Run one full frame's worth of ticks while capturing the serial line.
  // Optionally stall the tick stream, or inject a second tx_start mid-frame.
  task automatic capture(input int stall_at, input int extra_at, input logic [31:0] extra,
                         output logic [33:0] got, output bit stable,
                         output bit ready_ok, output bit stall_ok);
    logic ref_tx;
    logic exp_ready;
    got = '0; stable = 1'b1; ready_ok = 1'b1; stall_ok = 1'b1;
    for (int k = 0; k < NTICK; k++) begin
      if (k == stall_at) begin
        ref_tx = tx;
        repeat (50) begin
          @(negedge clk);
          if (tx !== ref_tx) stall_ok = 1'b0;
        end
      end
      if (k == extra_at) begin
        tx_data = extra; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end else begin
        @(negedge clk);
      end
      repeat (2) @(negedge clk);
      if (k % TPB == 0) got[k / TPB] = tx;
      else if (tx !== got[k / TPB]) stable = 1'b0;
      exp_ready = BUF ? !(extra_at >= 0 && k >= extra_at) : 1'b0;
      if (tx_ready !== exp_ready) ready_ok = 1'b0;
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [31:0] d);
    tx_data = d; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("accept_tx_low", tx, 1'b0);
    check("accept_busy", busy, 1'b1);
  endtask

  vec_t        vecs[5];
  logic [33:0] got;
  bit          stable, ready_ok, stall_ok;
  int          exp_done;

  initial begin
    rst = 1'b1; baud_tick = 1'b0; tx_start = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{32'hA5A5_0F0F, -1,  -1, 32'h0,         34'h3_4B4A_1E1E};
    vecs[1] = '{32'hDEAD_BEEF, 200, -1, 32'h0,         34'h3_BD5B_7DDE};
    vecs[2] = '{32'h0000_0000, -1,  -1, 32'h0,         34'h2_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, -1,  -1, 32'h0,         34'h3_FFFF_FFFE};
    vecs[4] = '{32'h1234_5678, -1,  BUF ? -1 : 100, 32'hCAFE_F00D, 34'h2_2468_ACF0};

    exp_done = 0;
    foreach (vecs[i]) begin
      start_frame(vecs[i].data);
      capture(vecs[i].stall_at, vecs[i].extra_at, vecs[i].extra, got, stable, ready_ok, stall_ok);
      exp_done++;
      check($sformatf("frame_%0d", i), got, vecs[i].exp_frame);
      check($sformatf("bit_width_%0d", i), stable, 1'b1);
      check($sformatf("ready_in_frame_%0d", i), ready_ok, 1'b1);
      if (vecs[i].stall_at >= 0) check("stall_tx_hold", stall_ok, 1'b1);
      check($sformatf("done_pulse_%0d", i), done, 1'b1);
      check($sformatf("busy_drop_%0d", i), busy, 1'b0);
      repeat (2) @(negedge clk);
      check($sformatf("done_once_%0d", i), done_cnt, exp_done);
      check($sformatf("idle_tx_%0d", i), tx, 1'b1);
      check($sformatf("idle_ready_%0d", i), tx_ready, 1'b1);
    end

    // Reset in the middle of a frame: line returns high, no done.
    start_frame(32'hFFFF_0000);
    idle_ticks(300);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", done_cnt, exp_done);
    start_frame(32'h0000_0001);
    capture(-1, -1, 32'h0, got, stable, ready_ok, stall_ok);
    exp_done++;
    check("post_rst_frame", got, 34'h2_0000_0002);
    check("post_rst_width", stable, 1'b1);
    check("post_rst_done", done, 1'b1);
    repeat (2) @(negedge clk);

`ifdef UART_32_BIT_TX_BUFFER_EN
    // Queue a second word mid-frame; it must follow with no idle bit.
    start_frame(32'h1111_1111);
    capture(-1, 100, 32'h2222_2222, got, stable, ready_ok, stall_ok);
    exp_done++;
    check("buf_frame1", got, 34'h2_2222_2222);
    check("buf_ready1", ready_ok, 1'b1);
    check("buf_done1", done, 1'b1);
    check("buf_chain_tx", tx, 1'b0);
    check("buf_chain_busy", busy, 1'b1);
    check("buf_drained_ready", tx_ready, 1'b1);
    capture(-1, -1, 32'h0, got, stable, ready_ok, stall_ok);
    exp_done++;
    check("buf_frame2", got, 34'h2_4444_4444);
    check("buf_width2", stable, 1'b1);
    check("buf_done2", done, 1'b1);
    check("buf_busy2", busy, 1'b0);
    repeat (2) @(negedge clk);
`endif
    check("total_done", done_cnt, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
